// File: rtl/csram_scanner.sv
// Walks every CSRAM entry once per tick: read, present the word downstream, then
// write back the updated membrane-potential field unless the consumer skips it.
module csram_scanner #(
  parameter int NUM_ELEMENT = 256,
  parameter int WIDTH       = 368,
  parameter int WRITE_INDEX = 103,
  parameter int WRITE_WIDTH = 9
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick_start,
  output logic                           busy,
  output logic                           scan_done,
  output logic                           csram_en,
  output logic                           csram_we,
  output logic [$clog2(NUM_ELEMENT)-1:0] csram_addr,
  output logic [WIDTH-1:0]               csram_di,
  input  logic [WIDTH-1:0]               csram_dout,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(NUM_ELEMENT)-1:0] out_addr,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [WRITE_WIDTH-1:0]         upd_data,
  input  logic                           upd_skip
);

  localparam int AW = $clog2(NUM_ELEMENT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ELEMENT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    PRESENT,
    WAIT_UPD,
    WRITE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  buf_q, buf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    scan_done  = 1'b0;
    csram_en   = 1'b0;
    csram_we   = 1'b0;
    csram_addr = '0;
    csram_di   = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_addr   = '0;
    upd_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick_start) begin
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        csram_en   = 1'b1;
        csram_addr = idx_q;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        buf_d   = csram_dout;
        state_d = PRESENT;
      end
      PRESENT: begin
        out_valid = 1'b1;
        out_data  = buf_q;
        out_addr  = idx_q;
        if (out_ready) state_d = WAIT_UPD;
      end
      WAIT_UPD: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          if (upd_skip) begin
            // Skipped entries advance straight from here, bypassing WRITE.
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = READ;
            end
          end else begin
            buf_d[WRITE_INDEX +: WRITE_WIDTH] = upd_data;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        csram_en   = 1'b1;
        csram_we   = 1'b1;
        csram_addr = idx_q;
        csram_di   = buf_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = READ;
        end
      end
      DONE: begin
        scan_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csram_scanner.sv
// Scoreboard bench for csram_scanner with a 4-entry synchronous RAM model.
module tb_csram_scanner;

  localparam int N  = 4;
  localparam int W  = 368;
  localparam int WI = 103;
  localparam int WW = 9;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, tick_start, busy, scan_done, csram_en, csram_we;
  logic          out_valid, out_ready, upd_valid, upd_ready, upd_skip;
  logic [AW-1:0] csram_addr, out_addr;
  logic [W-1:0]  csram_di, csram_dout, out_data;
  logic [WW-1:0] upd_data;

  logic [W-1:0]  mem [N];
  logic [W-1:0]  exp_mem [N];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_data;

  logic [AW-1:0] oq_a [$];
  logic [W-1:0]  oq_d [$];
  logic [AW-1:0] wq_a [$];
  logic [W-1:0]  wq_d [$];

  int total = 0;
  int bad   = 0;

  csram_scanner #(.NUM_ELEMENT(N)) dut (
    .clk(clk), .reset(reset), .tick_start(tick_start), .busy(busy),
    .scan_done(scan_done), .csram_en(csram_en), .csram_we(csram_we),
    .csram_addr(csram_addr), .csram_di(csram_di), .csram_dout(csram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_skip(upd_skip)
  );

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (csram_en) begin
      if (csram_we) mem[csram_addr] <= csram_di;
      else          csram_dout <= mem[csram_addr];
    end
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i += 32) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic load_mem();
    for (int i = 0; i < N; i++) begin
      load_data  = rand_word();
      load_addr  = AW'(i);
      load_en    = 1'b1;
      exp_mem[i] = load_data;
      @(negedge clk);
    end
    load_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},      W'(busy),       '0);
    check({tag, "_done"},      W'(scan_done),  '0);
    check({tag, "_en"},        W'(csram_en),   '0);
    check({tag, "_we"},        W'(csram_we),   '0);
    check({tag, "_oval"},      W'(out_valid),  '0);
    check({tag, "_urdy"},      W'(upd_ready),  '0);
    check({tag, "_caddr"},     W'(csram_addr), '0);
    check({tag, "_cdi"},       csram_di,       '0);
    check({tag, "_odata"},     out_data,       '0);
    check({tag, "_oaddr"},     W'(out_addr),   '0);
  endtask

  task automatic check_ram();
    for (int i = 0; i < N; i++) check($sformatf("ram%0d", i), mem[i], exp_mem[i]);
  endtask

  task automatic run_scan(input int stall_e, input int stall_len, input int skip_e,
                          input int abort_e, input int tick_again, input logic [WW-1:0] val);
    int n, done_cnt, done_at, st_cnt, cur, tail, exp_lat;
    bit aborted;
    logic [W-1:0]  hold_d, w;
    logic [AW-1:0] hold_a;

    for (int i = 0; i < N; i++) begin
      oq_a.push_back(AW'(i));
      oq_d.push_back(exp_mem[i]);
      if (i != skip_e && i != abort_e) begin
        w = exp_mem[i];
        w[WI +: WW] = val;
        wq_a.push_back(AW'(i));
        wq_d.push_back(w);
        exp_mem[i] = w;
      end
    end
    exp_lat = 5 * N + 1 + stall_len - ((skip_e >= 0) ? 1 : 0);

    upd_data   = val;
    upd_valid  = 1'b1;
    upd_skip   = 1'b0;
    out_ready  = 1'b1;
    tick_start = 1'b1;
    @(negedge clk);
    n = 1; done_cnt = 0; done_at = 0; st_cnt = 0; cur = -1; tail = 0; aborted = 0;
    hold_d = '0; hold_a = '0;

    while (n < 200 && !(done_cnt > 0 && tail >= 3)) begin
      tick_start = (n == tick_again);
      out_ready  = 1'b1;
      if (out_valid && int'(out_addr) == stall_e && st_cnt < stall_len) begin
        out_ready = 1'b0;
        if (st_cnt == 0) begin
          hold_d = out_data;
          hold_a = out_addr;
        end else begin
          check("stall_data", out_data, hold_d);
          check("stall_addr", W'(out_addr), W'(hold_a));
        end
        check("stall_no_en", W'(csram_en), '0);
        st_cnt++;
      end
      upd_skip = (cur == skip_e);
      if (upd_ready && cur == abort_e) begin
        reset     = 1'b1;
        upd_valid = 1'b0;
        aborted   = 1'b1;
      end
      if (done_cnt == 0) check("busy", W'(busy), W'(1));
      if (scan_done) begin
        done_cnt++;
        if (done_cnt == 1) done_at = n;
      end
      if (csram_we) begin
        check("we_needs_en", W'(csram_en), W'(1));
        check("wr_pending", W'(wq_a.size() > 0), W'(1));
        if (wq_a.size() > 0) begin
          check("wr_addr", W'(csram_addr), W'(wq_a.pop_front()));
          check("wr_data", csram_di, wq_d.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        check("out_pending", W'(oq_a.size() > 0), W'(1));
        if (oq_a.size() > 0) begin
          check("out_addr", W'(out_addr), W'(oq_a.pop_front()));
          check("out_data", out_data, oq_d.pop_front());
        end
        cur = int'(out_addr);
      end
      if (done_cnt > 0) tail++;
      @(negedge clk);
      n++;
      if (aborted) break;
    end
    tick_start = 1'b0;

    if (aborted) begin
      check_quiet("abort");
      check("abort_no_done", W'(done_cnt), '0);
      reset = 1'b0;
      @(negedge clk);
    end else begin
      check("scan_finished", W'(done_cnt > 0), W'(1));
      check("done_count", W'(done_cnt), W'(1));
      check("latency", W'(done_at), W'(exp_lat));
    end
    check("out_q_left", W'(oq_a.size()), '0);
    check("wr_q_left", W'(wq_a.size()), '0);
    oq_a.delete(); oq_d.delete(); wq_a.delete(); wq_d.delete();
    check_ram();
  endtask

  initial begin
    reset = 1'b1; tick_start = 1'b0; out_ready = 1'b0; upd_valid = 1'b0;
    upd_skip = 1'b0; upd_data = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    load_mem();
    run_scan(-1, 0, -1, -1, -1, 9'h1FF);
    load_mem();
    run_scan(2, 10, -1, -1, -1, 9'h0C3);
    load_mem();
    run_scan(-1, 0, 1, -1, -1, 9'h0A5);
    load_mem();
    run_scan(-1, 0, -1, -1, 7, 9'h033);
    load_mem();
    run_scan(-1, 0, -1, 3, -1, 9'h100);
    run_scan(-1, 0, -1, -1, -1, 9'h05A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csram_scanner.md
CSRAM_SCANNER -- requirements
Module: csram_scanner

Interface
REQ-001 The module SHALL have parameter NUM_ELEMENT, default 256: number of CSRAM entries scanned per tick.
REQ-002 The module SHALL have parameter WIDTH, default 368: CSRAM word width.
REQ-003 The module SHALL have parameter WRITE_INDEX, default 103: LSB position of the updatable field (membrane potential) within a word.
REQ-004 The module SHALL have parameter WRITE_WIDTH, default 9: width of the updatable field.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset, with ports as listed in REQ-006 to REQ-023.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 tick_start  input  1  single-cycle request to scan all entries.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 scan_done  output  1  one-cycle pulse when the scan completes.
REQ-011 csram_en  output  1  CSRAM enable.
REQ-012 csram_we  output  1  CSRAM write enable.
REQ-013 csram_addr  output  $clog2(NUM_ELEMENT)  CSRAM address.
REQ-014 csram_di  output  WIDTH  CSRAM write data.
REQ-015 csram_dout  input  WIDTH  CSRAM read data; valid the cycle after an en=1, we=0 cycle.
REQ-016 out_valid  output  1  entry stream valid.
REQ-017 out_ready  input  1  entry stream ready.
REQ-018 out_data  output  WIDTH  entry word.
REQ-019 out_addr  output  $clog2(NUM_ELEMENT)  index of the entry on out_data.
REQ-020 upd_valid  input  1  updated field valid.
REQ-021 upd_ready  output  1  module accepts an updated field.
REQ-022 upd_data  input  WRITE_WIDTH  new field value.
REQ-023 upd_skip  input  1  qualifies upd_valid: when high, suppress the write-back.

Function
REQ-024 The state machine SHALL have states IDLE, READ, CAPTURE, PRESENT, WAIT_UPD, WRITE and DONE.
REQ-025 In IDLE, tick_start=1 SHALL clear idx to 0 and enter READ; tick_start SHALL be ignored in every other state.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 In READ: csram_en=1, csram_we=0, csram_addr=idx; the next state SHALL be CAPTURE.
REQ-028 In CAPTURE: csram_en=0 and csram_dout is latched into buf; the next state SHALL be PRESENT.
REQ-029 In PRESENT: out_valid=1, out_data=buf, out_addr=idx, all held stable until out_ready=1; the transfer SHALL enter WAIT_UPD.
REQ-030 In WAIT_UPD: upd_ready=1; upd_valid=1 with upd_skip=0 SHALL set buf[WRITE_INDEX +: WRITE_WIDTH]=upd_data and enter WRITE.
REQ-031 upd_valid=1 with upd_skip=1 SHALL leave buf unchanged and skip WRITE, advancing as in REQ-033.
REQ-032 In WRITE: csram_en=1, csram_we=1, csram_addr=idx, csram_di=buf; bits outside the field SHALL equal the word read.
REQ-033 After WRITE or a skip: idx==NUM_ELEMENT-1 SHALL enter DONE; otherwise idx SHALL increment and the next state SHALL be READ.
REQ-034 In DONE: scan_done=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-035 The minimum per-entry cost SHALL be 5 cycles with write-back, 4 with skip; a full scan with no stalls SHALL take 5*NUM_ELEMENT+1 cycles from the tick_start edge to scan_done.
REQ-036 csram_en, csram_we, out_valid and upd_ready SHALL be 0 in any state not listed for them; csram_we=1 SHALL never occur without csram_en=1.
REQ-037 Stalls on out_ready or upd_valid of any length SHALL lose or duplicate no entry.

Reset
REQ-038 reset=1 SHALL force IDLE, idx=0, buf=0, and busy, scan_done, csram_en, csram_we, out_valid and upd_ready to 0, with csram_addr, csram_di, out_data and out_addr at 0.
REQ-039 reset asserted mid-scan SHALL abort the scan with no further CSRAM write and no scan_done pulse.

Verification
REQ-040 NUM_ELEMENT=4, out_ready=1, upd_valid=1, upd_data=9'h1FF: each word SHALL be written back with bits 111:103 = 1FF, other bits unchanged, and scan_done SHALL assert 21 cycles after tick_start.
REQ-041 out_ready held 0 for 10 cycles on entry 2: out_data and out_addr=2 SHALL stay constant, with no CSRAM access during the stall.
REQ-042 upd_skip=1 on entry 1: entry 1 SHALL show no csram_we pulse, its RAM contents SHALL be unchanged, and entry 2 SHALL follow normally.
REQ-043 tick_start pulsed mid-scan: the scan SHALL be unaffected, with exactly one scan_done.
REQ-044 reset asserted during WAIT_UPD of entry 3: all outputs SHALL be 0 the next cycle, entry 3 SHALL be unmodified, and a new tick_start SHALL restart from address 0.
